// File: rtl/column_mac_unit_pkg.sv
// Shared coprocessor definitions: FSM encodings, mode constants and the
// single-precision arithmetic used by the handshake sub-units.
package column_mac_unit_pkg;

  typedef enum logic [2:0] {IDLE, ISSUE, MULT, ACC, DONE} state_t;
  typedef enum logic [1:0] {U_GET, U_CALC, U_PUT} unit_state_t;

  localparam logic MODE_ELEM = 1'b0;
  localparam logic MODE_DOT  = 1'b1;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

  // Zero operands (including denormals) flush to a signed zero; mantissa truncates.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        sign;
    logic [7:0]  exp_sum;
    logic [47:0] prod;
    sign = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {sign, 31'd0};
    prod    = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    exp_sum = a[30:23] + b[30:23] - 8'd127;
    if (prod[47]) return {sign, exp_sum + 8'd1, 23'(prod >> 24)};
    return {sign, exp_sum, 23'(prod >> 23)};
  endfunction

  // Exact cancellation yields +0, so dot products are independent of lane count.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [23:0] mx, my;
    logic [24:0] sum;
    logic [7:0]  sh;
    int          msb;
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    mx  = (x[30:23] == 8'd0) ? 24'd0 : {1'b1, x[22:0]};
    my  = (y[30:23] == 8'd0) ? 24'd0 : {1'b1, y[22:0]};
    my  = my >> (x[30:23] - y[30:23]);
    sum = (x[31] == y[31]) ? ({1'b0, mx} + {1'b0, my}) : ({1'b0, mx} - {1'b0, my});
    if (sum == 25'd0) return FP_ZERO;
    msb = 0;
    for (int i = 0; i < 25; i++) if (sum[i]) msb = i;
    if (msb == 24) return {x[31], x[30:23] + 8'd1, 23'(sum >> 1)};
    sh = 8'(23 - msb);
    return {x[31], x[30:23] - sh, 23'(sum << sh)};
  endfunction

endpackage

// File: rtl/column_mac_unit_mac_lane.sv
// One multiplier lane: owns the operand strobes, the captured product and the done flag.
module mac_lane (
  input  logic        in_clk,
  input  logic        in_reset,
  input  logic        unit_rst,
  input  logic        start,
  input  logic        clear,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        done,
  output logic [31:0] prod
);
  logic        stb, z_ack, a_ack, b_ack, z_stb;
  logic [31:0] z;

  single_multiplier u_mult (
    .clk          (in_clk),
    .rst          (unit_rst),
    .input_a      (op_a),
    .input_a_stb  (stb),
    .input_a_ack  (a_ack),
    .input_b      (op_b),
    .input_b_stb  (stb),
    .input_b_ack  (b_ack),
    .output_z     (z),
    .output_z_stb (z_stb),
    .output_z_ack (z_ack)
  );

  // z_ack guard keeps a still-high z_stb from being captured twice.
  always_ff @(posedge in_clk) begin
    if (!in_reset) begin
      stb   <= 1'b0;
      z_ack <= 1'b0;
      done  <= 1'b0;
      prod  <= '0;
    end else begin
      z_ack <= 1'b0;
      if (start) begin
        stb  <= 1'b1;
        done <= 1'b0;
      end else if (stb && a_ack && b_ack) begin
        stb <= 1'b0;
      end
      if (z_stb && !done && !z_ack && !unit_rst) begin
        prod  <= z;
        done  <= 1'b1;
        z_ack <= 1'b1;
        stb   <= 1'b0;
      end
      if (clear) done <= 1'b0;
    end
  end
endmodule

// File: rtl/single_adder.sv
// Single-precision adder behind the a/b stb/ack, z stb/ack handshake.
module single_adder
  import column_mac_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);
  unit_state_t state, state_next;
  logic [31:0] a_q, b_q;

  always_ff @(posedge clk) begin
    if (rst) state <= U_GET;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (state == U_GET && input_a_stb && input_b_stb) begin
      a_q <= input_a;
      b_q <= input_b;
    end
    if (state == U_CALC) output_z <= fp_add(a_q, b_q);
  end

  always_comb begin
    state_next   = state;
    input_a_ack  = 1'b0;
    input_b_ack  = 1'b0;
    output_z_stb = 1'b0;
    case (state)
      U_GET: begin
        input_a_ack = 1'b1;
        input_b_ack = 1'b1;
        if (input_a_stb && input_b_stb) state_next = U_CALC;
      end
      U_CALC: state_next = U_PUT;
      U_PUT: begin
        output_z_stb = 1'b1;
        if (output_z_ack) state_next = U_GET;
      end
      default: state_next = U_GET;
    endcase
  end
endmodule

// File: rtl/single_multiplier.sv
// Single-precision multiplier behind the a/b stb/ack, z stb/ack handshake.
module single_multiplier
  import column_mac_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);
  unit_state_t state, state_next;
  logic [31:0] a_q, b_q;

  always_ff @(posedge clk) begin
    if (rst) state <= U_GET;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (state == U_GET && input_a_stb && input_b_stb) begin
      a_q <= input_a;
      b_q <= input_b;
    end
    if (state == U_CALC) output_z <= fp_mul(a_q, b_q);
  end

  always_comb begin
    state_next   = state;
    input_a_ack  = 1'b0;
    input_b_ack  = 1'b0;
    output_z_stb = 1'b0;
    case (state)
      U_GET: begin
        input_a_ack = 1'b1;
        input_b_ack = 1'b1;
        if (input_a_stb && input_b_stb) state_next = U_CALC;
      end
      U_CALC: state_next = U_PUT;
      U_PUT: begin
        output_z_stb = 1'b1;
        if (output_z_ack) state_next = U_GET;
      end
      default: state_next = U_GET;
    endcase
  end
endmodule

// File: rtl/column_mac_unit.sv
// Lane-parallel column multiplier: elementwise product or dot product of two packed columns.
//   state | meaning
//   IDLE  | waiting for in_ready, sub-units held in reset
//   ISSUE | start all lanes on the current group of cells
//   MULT  | waiting for every lane product
//   ACC   | dot mode: add group products into accumulator, ascending cell index
//   DONE  | out_c valid, waiting for out_ack
module column_mac_unit
  import column_mac_unit_pkg::*;
#(
  parameter  int size       = 4,
  parameter  int cell_width = 32,
  parameter  int lanes      = 2,
  localparam int width      = cell_width * size
) (
  input  logic             in_clk,
  input  logic             in_reset,
  input  logic [width-1:0] in_a,
  input  logic [width-1:0] in_b,
  input  logic             in_mode,
  input  logic             in_ready,
  input  logic             out_ack,
  output logic             out_busy,
  output logic             out_ready,
  output logic [width-1:0] out_c
);
  localparam int groups  = size / lanes;
  localparam int group_w = $clog2(groups) + 1;
  localparam int idx_w   = (lanes > 1) ? $clog2(lanes) : 1;

  if (size % lanes != 0) begin : g_bad_lanes
    $error("column_mac_unit: lanes must divide size");
  end

  state_t               state, state_next;
  logic [width-1:0]     a_q, b_q;
  logic                 mode_q;
  logic [group_w-1:0]   group;
  logic [idx_w-1:0]     add_idx;
  logic [31:0]          acc, add_z, add_b;
  logic [lanes-1:0]     lane_done;
  logic [31:0]          lane_prod [lanes];
  logic                 add_stb, add_zack, add_a_ack, add_b_ack, add_z_stb;
  logic                 unit_rst, all_done, last_group, last_add, add_take;

  assign unit_rst   = (state == IDLE);
  assign all_done   = &lane_done;
  assign last_group = (group == group_w'(groups - 1));
  assign last_add   = (add_idx == idx_w'(lanes - 1));
  assign add_take   = (state == ACC) && add_z_stb && !add_zack;
  assign out_busy   = (state != IDLE);
  assign out_ready  = (state == DONE);

  for (genvar k = 0; k < lanes; k++) begin : g_lane
    logic [31:0] op_a, op_b;
    assign op_a = a_q[(int'(group) * lanes + k) * cell_width +: cell_width];
    assign op_b = b_q[(int'(group) * lanes + k) * cell_width +: cell_width];
    mac_lane u_lane (
      .in_clk   (in_clk),
      .in_reset (in_reset),
      .unit_rst (unit_rst),
      .start    (state == ISSUE),
      .clear    ((state == MULT) && all_done),
      .op_a     (op_a),
      .op_b     (op_b),
      .done     (lane_done[k]),
      .prod     (lane_prod[k])
    );
  end

  always_comb begin
    add_b = lane_prod[0];
    for (int k = 0; k < lanes; k++) if (add_idx == idx_w'(k)) add_b = lane_prod[k];
  end

  single_adder u_add (
    .clk          (in_clk),
    .rst          (unit_rst),
    .input_a      (acc),
    .input_a_stb  (add_stb),
    .input_a_ack  (add_a_ack),
    .input_b      (add_b),
    .input_b_stb  (add_stb),
    .input_b_ack  (add_b_ack),
    .output_z     (add_z),
    .output_z_stb (add_z_stb),
    .output_z_ack (add_zack)
  );

  always_ff @(posedge in_clk) begin
    if (!in_reset) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (in_ready) state_next = ISSUE;
      ISSUE: state_next = MULT;
      MULT: begin
        if (all_done) begin
          if (mode_q == MODE_DOT) state_next = ACC;
          else if (last_group)    state_next = DONE;
          else                    state_next = ISSUE;
        end
      end
      ACC:   if (add_take && last_add) state_next = last_group ? DONE : ISSUE;
      DONE:  if (out_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (!in_reset) begin
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= MODE_ELEM;
      group    <= '0;
      add_idx  <= '0;
      acc      <= FP_ZERO;
      out_c    <= '0;
      add_stb  <= 1'b0;
      add_zack <= 1'b0;
    end else begin
      add_zack <= 1'b0;
      case (state)
        IDLE: begin
          if (in_ready) begin
            a_q    <= in_a;
            b_q    <= in_b;
            mode_q <= in_mode;
            out_c  <= '0;
            acc    <= FP_ZERO;
            group  <= '0;
          end
        end
        MULT: begin
          if (all_done) begin
            if (mode_q == MODE_DOT) begin
              add_stb <= 1'b1;
              add_idx <= '0;
            end else begin
              for (int k = 0; k < lanes; k++)
                out_c[(int'(group) * lanes + k) * cell_width +: cell_width] <= lane_prod[k];
              if (!last_group) group <= group + 1'b1;
            end
          end
        end
        ACC: begin
          if (add_stb && add_a_ack && add_b_ack) add_stb <= 1'b0;
          if (add_take) begin
            acc      <= add_z;
            add_zack <= 1'b1;
            if (!last_add) begin
              add_idx <= add_idx + 1'b1;
              add_stb <= 1'b1;
            end else if (last_group) begin
              out_c[cell_width-1:0] <= add_z;
            end else begin
              group <= group + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_column_mac_unit.sv
// Bench for column_mac_unit: three instances (lanes 2, 1, 4) share stimulus and are
// compared against an integer-arithmetic reference of the expected FP bit patterns.
module tb_column_mac_unit;
  localparam int CW   = 32;
  localparam int SIZE = 4;
  localparam int W    = CW * SIZE;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mode;
    logic [W-1:0] expc;
  } vec_t;

  logic         in_clk = 1'b0;
  logic         in_reset = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic         in_mode = 1'b0, in_ready = 1'b0, out_ack = 1'b0;
  logic         busy2, rdy2, busy1, rdy1, busy4, rdy4;
  logic [W-1:0] c2, c1, c4;
  int           checks = 0;
  int           errors = 0;
  vec_t         vecs[$];

  always #5 in_clk = ~in_clk;

  column_mac_unit #(.size(SIZE), .cell_width(CW), .lanes(2)) dut (
    .in_clk(in_clk), .in_reset(in_reset), .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .in_ready(in_ready), .out_ack(out_ack), .out_busy(busy2), .out_ready(rdy2), .out_c(c2));
  column_mac_unit #(.size(SIZE), .cell_width(CW), .lanes(1)) dut_l1 (
    .in_clk(in_clk), .in_reset(in_reset), .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .in_ready(in_ready), .out_ack(out_ack), .out_busy(busy1), .out_ready(rdy1), .out_c(c1));
  column_mac_unit #(.size(SIZE), .cell_width(CW), .lanes(4)) dut_l4 (
    .in_clk(in_clk), .in_reset(in_reset), .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .in_ready(in_ready), .out_ack(out_ack), .out_busy(busy4), .out_ready(rdy4), .out_c(c4));

  function automatic logic [31:0] to_fp(input int v);
    int          m, p;
    logic [31:0] mm;
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 31; i++) if (((m >> i) & 1) == 1) p = i;
    mm = 32'(m) << (23 - p);
    return {(v < 0), 8'(127 + p), mm[22:0]};
  endfunction

  function automatic logic [W-1:0] pack(input int c [SIZE]);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < SIZE; i++) r[i*CW +: CW] = to_fp(c[i]);
    return r;
  endfunction

  function automatic int rnd_cell();
    int m;
    m = int'($urandom_range(1, 8));
    return ($urandom_range(0, 1) == 1) ? -m : m;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic mode);
    @(negedge in_clk);
    in_a = a; in_b = b; in_mode = mode; in_ready = 1'b1;
    @(negedge in_clk);
    in_ready = 1'b0;
    in_a = {$urandom, $urandom, $urandom, $urandom};
    in_b = {$urandom, $urandom, $urandom, $urandom};
    in_mode = ~mode;
  endtask

  task automatic collect(input string name, input logic [W-1:0] exp, input int hold);
    int n;
    n = 0;
    while (!(rdy1 && rdy2 && rdy4) && n < 400) begin
      @(negedge in_clk);
      n++;
    end
    check({name, " ready"}, W'({rdy1, rdy2, rdy4}), W'(3'b111));
    check({name, " l2"}, c2, exp);
    check({name, " l1"}, c1, exp);
    check({name, " l4"}, c4, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge in_clk);
      check({name, " hold ready"}, W'({rdy1, rdy2, rdy4}), W'(3'b111));
      check({name, " hold c"}, c2, exp);
    end
    out_ack = 1'b1;
    @(negedge in_clk);
    out_ack = 1'b0;
    check({name, " idle after ack"}, W'({rdy1, rdy2, rdy4, busy1, busy2, busy4}), '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ca[SIZE], cb[SIZE];
    vec_t v;
    logic [W-1:0] e1, e2;

    ca = '{1, 2, 3, 4}; cb = '{2, 2, 2, 2};
    e1 = {32'h41000000, 32'h40C00000, 32'h40800000, 32'h40000000};
    e2 = W'(32'h41A00000);
    vecs.push_back('{"spec elem", pack(ca), pack(cb), 1'b0, e1});
    vecs.push_back('{"spec dot", pack(ca), pack(cb), 1'b1, e2});
    ca = '{1, -1, 1, -1}; cb = '{1, 1, 1, 1};
    vecs.push_back('{"spec cancel", pack(ca), pack(cb), 1'b1, W'(0)});
    for (int r = 0; r < 14; r++) begin
      int sum;
      sum = 0;
      v.name = $sformatf("rand%0d", r);
      v.mode = ($urandom_range(0, 1) == 1);
      v.expc = '0;
      for (int i = 0; i < SIZE; i++) begin
        ca[i] = rnd_cell();
        cb[i] = rnd_cell();
        sum += ca[i] * cb[i];
        v.expc[i*CW +: CW] = to_fp(ca[i] * cb[i]);
      end
      if (v.mode) v.expc = W'(to_fp(sum));
      v.a = pack(ca);
      v.b = pack(cb);
      vecs.push_back(v);
    end

    repeat (3) @(negedge in_clk);
    check("reset outputs", W'({rdy1, rdy2, rdy4, busy1, busy2, busy4}), '0);
    check("reset out_c", c2 | c1 | c4, '0);
    in_reset = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].mode);
      collect(vecs[i].name, vecs[i].expc, 2);
    end

    // in_ready while busy must be dropped, not queued
    ca = '{1, 2, 3, 4}; cb = '{2, 2, 2, 2};
    issue(pack(ca), pack(cb), 1'b0);
    @(negedge in_clk);
    ca = '{7, 7, 7, 7};
    in_a = pack(ca); in_mode = 1'b1; in_ready = 1'b1;
    @(negedge in_clk);
    in_ready = 1'b0;
    collect("busy ignore", e1, 0);
    repeat (3) @(negedge in_clk);
    check("no queued request", W'({busy1, busy2, busy4}), '0);

    // reset pulse in the middle of MULT
    ca = '{1, 2, 3, 4};
    @(negedge in_clk);
    in_a = pack(ca); in_b = pack(cb); in_mode = 1'b1; in_ready = 1'b1;
    @(negedge in_clk);
    in_ready = 1'b0;
    @(negedge in_clk);
    in_reset = 1'b0;
    @(negedge in_clk);
    in_reset = 1'b1;
    check("mid reset flags", W'({rdy1, rdy2, rdy4, busy1, busy2, busy4}), '0);
    check("mid reset out_c", c2 | c1 | c4, '0);
    repeat (10) @(negedge in_clk);
    check("no partial result", W'({rdy1, rdy2, rdy4, busy1, busy2, busy4}), '0);
    issue(pack(ca), pack(cb), 1'b1);
    collect("after reset", e2, 0);

    // long hold in DONE
    issue(pack(ca), pack(cb), 1'b1);
    collect("long hold", e2, 50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
